rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Write-back arbiter and scoreboard in front of the 32x32 register file's single write port (rd_wren/rd_addr/rd_data).
- Shares the write port between the ALU write-back path and the long-latency load/store unit (LSU) using round-robin arbitration.
- Tracks destination registers of in-flight LSU loads in a pending scoreboard, so the issue logic can stall on RAW and WAW hazards.
- Sits between the execute/LSU stages and the register file.

Parameters:
XLEN, 32, data width of write-back values
NREG, 32, number of architectural registers; the scoreboard has NREG bits
AW, 5, register address width; must equal clog2(NREG)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active-low
i_alu_valid  in  1  ALU write-back request
i_alu_rd_addr  in  AW  ALU destination register
i_alu_rd_data  in  XLEN  ALU result
o_alu_ready  out  1  ALU request granted this cycle
i_lsu_valid  in  1  LSU write-back request
i_lsu_rd_addr  in  AW  LSU destination register
i_lsu_rd_data  in  XLEN  load data
o_lsu_ready  out  1  LSU request granted this cycle
i_issue_valid  in  1  an instruction issues this cycle
i_issue_long  in  1  the issuing instruction is an LSU load, so its rd becomes pending
i_issue_rd_addr  in  AW  issuing instruction's rd
i_rs1_addr  in  AW  source register 1 of the instruction in issue
i_rs2_addr  in  AW  source register 2 of the instruction in issue
o_rs1_busy  out  1  rs1 is pending
o_rs2_busy  out  1  rs2 is pending
o_waw_stall  out  1  issue rd is already pending
o_rd_wren  out  1  register-file write enable
o_rd_addr  out  AW  register-file write address
o_rd_data  out  XLEN  register-file write data

Behaviour:
- Reset (synchronous, i_rst_n=0 at posedge):
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - Scoreboard pending[NREG-1:0] = 0.
  - last_grant = LSU, so the ALU wins the first conflict.
  - o_*_ready, busy and stall outputs are combinational and evaluate to 0 while reset is asserted.
- Arbitration (combinational grant, two-state last_grant register):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - last_grant updates only on a grant.
  - o_x_ready = grant_x; it is never asserted without the matching valid.
- Handshake:
  - A requester holds valid, rd_addr and rd_data stable until ready is seen.
  - Transfer occurs on the posedge where valid && ready.
  - A requester may deassert valid only after its transfer.
- Write port timing:
  - Registered, one-cycle latency: grant at cycle N gives o_rd_wren/addr/data in cycle N+1.
  - No grant at N gives o_rd_wren=0 in N+1; addr and data hold their previous values.
- x0 writes:
  - Granted normally (ready=1), but o_rd_wren stays 0.
  - Scoreboard bit 0 is never set.
- Scoreboard:
  - Set pending[rd] on i_issue_valid && i_issue_long && rd!=0 && !o_waw_stall.
  - Clear pending[rd] on an LSU transfer.
  - Set and clear of the same index in the same cycle: set wins.
  - o_rsN_busy = pending[i_rsN_addr]; always 0 for x0.
  - Busy reflects the registered pending state. Because of the write-port latency, a register is cleared in the same cycle its data reaches the register file, so the following read is correct.
- o_waw_stall = i_issue_valid && i_issue_rd_addr!=0 && pending[i_issue_rd_addr]. It applies to both long and short instructions.
- ALU requests never touch the scoreboard.
- Reset mid-operation: in-flight grants are dropped, pending is cleared, and no write is emitted in the cycle after reset.

Optional Feature:
RF_WB_BYPASS_EN
- Defined: adds outputs o_rs1_fwd (1), o_rs2_fwd (1) and o_fwd_data (XLEN).
- o_rsN_fwd = o_rd_wren && o_rd_addr==i_rsN_addr && i_rsN_addr!=0, which forwards the registered write to the issue stage in the same cycle.
- When fwd is asserted for a source, its busy output is forced to 0.
- Undefined: these ports do not exist, and behaviour is exactly as above.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN, NREG, AW constants.
  - typedef wb_req_t {valid, rd_addr, rd_data}.
  - enum grant_e {GNT_ALU, GNT_LSU}.
- One natural sub-module, rf_scoreboard: the pending vector with set/clear/lookup and WAW detect.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset, then ALU valid rd=5 data=0xDEADBEEF alone -> o_alu_ready=1 at N; o_rd_wren=1, addr=5, data=0xDEADBEEF at N+1.
- ALU (rd=3) and LSU (rd=4) both valid and held for 2 cycles -> ALU granted first, LSU second; writes to x3 then x4 on consecutive cycles; last_grant alternates across 4 cycles of continuous contention.
- Issue long rd=7, then rs1=7 -> o_rs1_busy=1 until LSU rd=7 transfers; 0 from the next cycle; issuing rd=7 while pending -> o_waw_stall=1.
- LSU write rd=9 and issue long rd=9 in the same cycle -> pending[9]=1 afterward (set wins); ALU/LSU write to x0 -> ready=1, o_rd_wren=0.
- Reset asserted while pending[12]=1 and the LSU is waiting -> pending=0, o_rd_wren=0 the cycle after reset, o_lsu_ready=0 during reset.
- With RF_WB_BYPASS_EN: write x6=0x1234 at N+1 with rs2=6 -> o_rs2_fwd=1, o_fwd_data=0x1234, o_rs2_busy=0.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, write-back request bundle and grant encoding for the
// register-file write-back arbiter.
package rf_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: ALU and LSU request channels plus the register-file write port.
interface rf_wb_if;
  import rf_pkg::*;

  logic            i_alu_valid;
  logic [AW-1:0]   i_alu_rd_addr;
  logic [XLEN-1:0] i_alu_rd_data;
  logic            o_alu_ready;

  logic            i_lsu_valid;
  logic [AW-1:0]   i_lsu_rd_addr;
  logic [XLEN-1:0] i_lsu_rd_data;
  logic            o_lsu_ready;

  logic            o_rd_wren;
  logic [AW-1:0]   o_rd_addr;
  logic [XLEN-1:0] o_rd_data;

  // Requesting side (execute/LSU stages and the register file view)
  modport master (
    output i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    input  o_alu_ready,
    output i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    input  o_lsu_ready,
    input  o_rd_wren, o_rd_addr, o_rd_data
  );

  modport slave (
    input  i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    output o_alu_ready,
    input  i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    output o_lsu_ready,
    output o_rd_wren, o_rd_addr, o_rd_data
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set at long
// issue, cleared on LSU write-back, looked up for RAW/WAW hazards.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned SB_NREG = NREG,
  parameter int unsigned SB_AW   = AW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue_valid,
  input  logic             i_issue_long,
  input  logic [SB_AW-1:0] i_issue_rd_addr,
  input  logic             i_clr_en,
  input  logic [SB_AW-1:0] i_clr_addr,
  input  logic [SB_AW-1:0] i_rs1_addr,
  input  logic [SB_AW-1:0] i_rs2_addr,
  output logic             o_rs1_pend,
  output logic             o_rs2_pend,
  output logic             o_waw_stall
);

  logic [SB_NREG-1:0] pending_q;
  logic [SB_NREG-1:0] pending_d;
  logic               set_en;

  always_comb begin
    pending_d   = pending_q;
    o_waw_stall = i_rst_n && i_issue_valid && (i_issue_rd_addr != '0)
                  && pending_q[i_issue_rd_addr];
    set_en      = i_issue_valid && i_issue_long && (i_issue_rd_addr != '0)
                  && !o_waw_stall;
    // Clear first so a same-cycle set of the same index takes precedence
    if (i_clr_en) pending_d[i_clr_addr] = 1'b0;
    if (set_en)   pending_d[i_issue_rd_addr] = 1'b1;
  end

  always_comb begin
    o_rs1_pend = i_rst_n && (i_rs1_addr != '0) && pending_q[i_rs1_addr];
    o_rs2_pend = i_rst_n && (i_rs2_addr != '0) && pending_q[i_rs2_addr];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin ALU/LSU write-back arbiter with a registered register-file write
// port and pending-load scoreboard. Optional forwarding: RF_WB_BYPASS_EN.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  rf_wb_if.slave          wb,
  input  logic            i_issue_valid,
  input  logic            i_issue_long,
  input  logic [AW-1:0]   i_issue_rd_addr,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
`ifdef RF_WB_BYPASS_EN
  output logic            o_rs1_fwd,
  output logic            o_rs2_fwd,
  output logic [XLEN-1:0] o_fwd_data,
`endif
  output logic            o_waw_stall
);

  wb_req_t         alu_req;
  wb_req_t         lsu_req;
  grant_e          last_grant_q, last_grant_d;
  logic            gnt_alu, gnt_lsu;
  logic            rd_wren_q, rd_wren_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rs1_pend, rs2_pend;
  logic            rs1_fwd, rs2_fwd;

  always_comb begin
    alu_req = '{valid: wb.i_alu_valid, rd_addr: wb.i_alu_rd_addr, rd_data: wb.i_alu_rd_data};
    lsu_req = '{valid: wb.i_lsu_valid, rd_addr: wb.i_lsu_rd_addr, rd_data: wb.i_lsu_rd_data};
  end

  // Contention goes to whoever did not win last; a lone requester always wins
  always_comb begin
    gnt_alu      = 1'b0;
    gnt_lsu      = 1'b0;
    last_grant_d = last_grant_q;
    if (i_rst_n) begin
      if (alu_req.valid && (!lsu_req.valid || last_grant_q == GNT_LSU)) gnt_alu = 1'b1;
      else if (lsu_req.valid)                                            gnt_lsu = 1'b1;
    end
    if (gnt_alu)      last_grant_d = GNT_ALU;
    else if (gnt_lsu) last_grant_d = GNT_LSU;
  end

  // x0 writes complete the handshake but never strobe the write enable
  always_comb begin
    rd_wren_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (gnt_alu) begin
      rd_wren_d = (alu_req.rd_addr != '0);
      rd_addr_d = alu_req.rd_addr;
      rd_data_d = alu_req.rd_data;
    end else if (gnt_lsu) begin
      rd_wren_d = (lsu_req.rd_addr != '0);
      rd_addr_d = lsu_req.rd_addr;
      rd_data_d = lsu_req.rd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant_q <= GNT_LSU;
      rd_wren_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_wren_q    <= rd_wren_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_comb begin
    wb.o_alu_ready = gnt_alu;
    wb.o_lsu_ready = gnt_lsu;
    wb.o_rd_wren   = rd_wren_q;
    wb.o_rd_addr   = rd_addr_q;
    wb.o_rd_data   = rd_data_q;
  end

  rf_scoreboard #(
    .SB_NREG (NREG),
    .SB_AW   (AW)
  ) u_scoreboard (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_issue_valid   (i_issue_valid),
    .i_issue_long    (i_issue_long),
    .i_issue_rd_addr (i_issue_rd_addr),
    .i_clr_en        (gnt_lsu),
    .i_clr_addr      (lsu_req.rd_addr),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_rs1_pend      (rs1_pend),
    .o_rs2_pend      (rs2_pend),
    .o_waw_stall     (o_waw_stall)
  );

`ifdef RF_WB_BYPASS_EN
  // The registered write is visible to issue in the same cycle it lands
  always_comb begin
    rs1_fwd    = i_rst_n && rd_wren_q && (rd_addr_q == i_rs1_addr) && (i_rs1_addr != '0);
    rs2_fwd    = i_rst_n && rd_wren_q && (rd_addr_q == i_rs2_addr) && (i_rs2_addr != '0);
    o_rs1_fwd  = rs1_fwd;
    o_rs2_fwd  = rs2_fwd;
    o_fwd_data = rd_data_q;
  end
`else
  always_comb begin
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
  end
`endif

  always_comb begin
    o_rs1_busy = rs1_pend && !rs1_fwd;
    o_rs2_busy = rs2_pend && !rs2_fwd;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, then random
// traffic against a behavioural model of arbitration, write port and scoreboard.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  rf_wb_if wb ();
  logic       iv, il;
  logic [4:0] ird, rs1, rs2;
  logic       b1, b2, waw;
`ifdef RF_WB_BYPASS_EN
  logic        f1, f2;
  logic [31:0] fd;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic rst_n;

  rf_wb_arbiter dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .wb              (wb),
    .i_issue_valid   (iv),
    .i_issue_long    (il),
    .i_issue_rd_addr (ird),
    .i_rs1_addr      (rs1),
    .i_rs2_addr      (rs2),
    .o_rs1_busy      (b1),
    .o_rs2_busy      (b2),
`ifdef RF_WB_BYPASS_EN
    .o_rs1_fwd       (f1),
    .o_rs2_fwd       (f2),
    .o_fwd_data      (fd),
`endif
    .o_waw_stall     (waw)
  );

  typedef struct packed {
    logic        rst_n;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic        il;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_ar;
    logic        e_lr;
    logic        e_b1;
    logic        e_b2;
    logic        e_waw;
    logic        e_wren;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Expected contents of the registered write port as currently visible
  logic        p_wren  = 1'b0;
  logic [4:0]  p_waddr = '0;
  logic [31:0] p_wdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fwd_exp(input logic r, input logic [4:0] rs);
    return BYP && r && p_wren && (p_waddr == rs) && (rs != 5'd0);
  endfunction

  task automatic run_vec(input vec_t v);
    rst_n            = v.rst_n;
    wb.i_alu_valid   = v.av;
    wb.i_alu_rd_addr = v.aa;
    wb.i_alu_rd_data = v.ad;
    wb.i_lsu_valid   = v.lv;
    wb.i_lsu_rd_addr = v.la;
    wb.i_lsu_rd_data = v.ld;
    iv  = v.iv;
    il  = v.il;
    ird = v.ird;
    rs1 = v.rs1;
    rs2 = v.rs2;
    #1;
    chk("alu_ready", 32'(wb.o_alu_ready), 32'(v.e_ar));
    chk("lsu_ready", 32'(wb.o_lsu_ready), 32'(v.e_lr));
    chk("rs1_busy",  32'(b1),  32'(v.e_b1));
    chk("rs2_busy",  32'(b2),  32'(v.e_b2));
    chk("waw_stall", 32'(waw), 32'(v.e_waw));
`ifdef RF_WB_BYPASS_EN
    chk("rs1_fwd", 32'(f1), 32'(fwd_exp(v.rst_n, v.rs1)));
    chk("rs2_fwd", 32'(f2), 32'(fwd_exp(v.rst_n, v.rs2)));
    if (fwd_exp(v.rst_n, v.rs1) || fwd_exp(v.rst_n, v.rs2))
      chk("fwd_data", fd, p_wdata);
`endif
    @(posedge clk);
    #1;
    chk("rd_wren", 32'(wb.o_rd_wren), 32'(v.e_wren));
    chk("rd_addr", 32'(wb.o_rd_addr), 32'(v.e_waddr));
    chk("rd_data", wb.o_rd_data, v.e_wdata);
    p_wren  = v.e_wren;
    p_waddr = v.e_waddr;
    p_wdata = v.e_wdata;
  endtask

  // Behavioural model state for the random phase
  bit          pend [32];
  bit          alu_prio;
  bit          ah, lh;
  logic [4:0]  aa_r, la_r;
  logic [31:0] ad_r, ld_r;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //                 rst av aa ad          lv la ld          iv il ird rs1 rs2  ar lr b1 b2 waw  wren waddr wdata
    tbl.push_back(vec_t'{1'b0,1'b1,5'd5, 32'h0,       1'b1,5'd3, 32'h0,  1'b1,1'b1,5'd2, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h0});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd5, 32'hDEADBEEF});
    tbl.push_back(vec_t'{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h0});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd3, 32'h33,      1'b1,5'd4, 32'h44, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd3, 32'h33});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd3, 32'h35,      1'b1,5'd4, 32'h44, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd4, 32'h44});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd3, 32'h35,      1'b1,5'd8, 32'h88, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd3, 32'h35});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd10,32'hAA,      1'b1,5'd8, 32'h88, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd8, 32'h88});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd8, 32'h88});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,1'b1,5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd8, 32'h88});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd7, 5'd7, 1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,5'd8, 32'h88});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,1'b0,5'd7, 5'd7, 5'd3, 1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,5'd8, 32'h88});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,1'b1,5'd7, 5'd7, 5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,5'd8, 32'h88});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd7, 32'h77, 1'b0,1'b0,5'd0, 5'd7, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,5'd7, 32'h77});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd7, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd7, 32'h77});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd9, 32'h99, 1'b1,1'b1,5'd9, 5'd9, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd9, 32'h99});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd9, 32'h99});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd9, 5'd9, 1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,5'd9, 32'h99});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd0, 32'h5,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h5});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd0, 32'h6,  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h6});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,1'b1,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h6});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,1'b1,5'd12,5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h6});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd1, 32'h1,       1'b1,5'd12,32'hC,  1'b0,1'b0,5'd0, 5'd12,5'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,5'd1, 32'h1});
    tbl.push_back(vec_t'{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd12,32'hC,  1'b0,1'b0,5'd0, 5'd12,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0, 32'h0});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd12,32'hC,  1'b0,1'b0,5'd0, 5'd12,5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd12,32'hC});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd12,5'd9, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd12,32'hC});
`ifdef RF_WB_BYPASS_EN
    // x6 pending, then written by the ALU: forwarding must hide the busy bit
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,1'b1,5'd6, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd12,32'hC});
    tbl.push_back(vec_t'{1'b1,1'b1,5'd6, 32'h1234,    1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd6, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,5'd6, 32'h1234});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd6, 32'h1234});
    tbl.push_back(vec_t'{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,1'b0,5'd0, 5'd0, 5'd6, 1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,5'd6, 32'h1234});
`endif

    foreach (tbl[i]) run_vec(tbl[i]);

    ah = 1'b0;
    lh = 1'b0;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      bit   ga, gl, fw1, fw2;
      v = '0;
      v.rst_n = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      if (!ah && $urandom_range(0, 1) == 1) begin
        ah = 1'b1; aa_r = 5'($urandom_range(0, 7)); ad_r = $urandom;
      end
      if (!lh && $urandom_range(0, 1) == 1) begin
        lh = 1'b1; la_r = 5'($urandom_range(0, 7)); ld_r = $urandom;
      end
      v.av = ah; v.aa = ah ? aa_r : 5'd0; v.ad = ah ? ad_r : 32'h0;
      v.lv = lh; v.la = lh ? la_r : 5'd0; v.ld = lh ? ld_r : 32'h0;
      v.iv  = 1'($urandom_range(0, 1));
      v.il  = 1'($urandom_range(0, 1));
      v.ird = 5'($urandom_range(0, 7));
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));

      ga  = v.rst_n && ah && (!lh || alu_prio);
      gl  = v.rst_n && lh && !ga;
      fw1 = fwd_exp(v.rst_n, v.rs1);
      fw2 = fwd_exp(v.rst_n, v.rs2);
      v.e_ar  = ga;
      v.e_lr  = gl;
      v.e_waw = v.rst_n && v.iv && (v.ird != 0) && pend[v.ird];
      v.e_b1  = v.rst_n && (v.rs1 != 0) && pend[v.rs1] && !fw1;
      v.e_b2  = v.rst_n && (v.rs2 != 0) && pend[v.rs2] && !fw2;
      if (!v.rst_n) begin
        v.e_wren = 1'b0; v.e_waddr = 5'd0; v.e_wdata = 32'h0;
      end else if (ga) begin
        v.e_wren = (aa_r != 0); v.e_waddr = aa_r; v.e_wdata = ad_r;
      end else if (gl) begin
        v.e_wren = (la_r != 0); v.e_waddr = la_r; v.e_wdata = ld_r;
      end else begin
        v.e_wren = 1'b0; v.e_waddr = p_waddr; v.e_wdata = p_wdata;
      end

      run_vec(v);

      if (!v.rst_n) begin
        foreach (pend[k]) pend[k] = 1'b0;
        alu_prio = 1'b1;
      end else begin
        if (ga) begin alu_prio = 1'b0; ah = 1'b0; end
        if (gl) begin alu_prio = 1'b1; lh = 1'b0; pend[la_r] = 1'b0; end
        if (v.iv && v.il && v.ird != 0 && !v.e_waw) pend[v.ird] = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
